fixed_to_float_seq: RTL and testbench

FIXED_TO_FLOAT_SEQ -- requirements
Module: fixed_to_float_seq

---
 rtl/fixed_to_float_seq_pkg.sv | 30 +++
 rtl/shift_reg_norm.sv | 41 ++++
 rtl/fixed_to_float_seq.sv | 139 +++++++++++++
 tb/tb_fixed_to_float_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fixed_to_float_seq_pkg.sv
// -----------------------------------------------------------------------------
// fixed_to_float_seq_pkg
// Shared constants and types for the fixed/float converters.
//   - Word width, exponent width and bias of IEEE-754 single precision.
//   - Hidden-bit position of the normalized magnitude and the mantissa slice.
//   - FSM state encoding and the magnitude-register operation encoding.
// -----------------------------------------------------------------------------
package fixed_to_float_seq_pkg;

   localparam int F2F_WORD_W     = 32;
   localparam int F2F_EXP_W      = 8;
   localparam int F2F_EXP_BIAS   = 127;
   localparam int F2F_HIDDEN_BIT = 26;
   localparam int F2F_MANT_HI    = 25;
   localparam int F2F_MANT_LO    = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_PACK = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MAG_HOLD = 2'd0,
      MAG_LOAD = 2'd1,
      MAG_SHL  = 2'd2,
      MAG_SHR  = 2'd3
   } mag_op_t;

endpackage

// File: rtl/shift_reg_norm.sv
// -----------------------------------------------------------------------------
// shift_reg_norm
// Magnitude register used during normalization: load, shift left by one,
// shift right by one (logical), or hold.
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset, clears the register
//   i_op       operation select (mag_op_t)
//   i_load_val value taken on MAG_LOAD
//   o_mag      current register contents
// -----------------------------------------------------------------------------
module shift_reg_norm
   import fixed_to_float_seq_pkg::*;
#(
   parameter int W = F2F_WORD_W
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  mag_op_t       i_op,
   input  logic [W-1:0]  i_load_val,
   output logic [W-1:0]  o_mag
);

   logic [W-1:0] r_mag;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mag <= '0;
      end else begin
         case (i_op)
            MAG_LOAD: r_mag <= i_load_val;
            MAG_SHL:  r_mag <= {r_mag[W-2:0], 1'b0};
            MAG_SHR:  r_mag <= {1'b0, r_mag[W-1:1]};
            default:  r_mag <= r_mag;
         endcase
      end
   end

   assign o_mag = r_mag;

endmodule

// File: rtl/fixed_to_float_seq.sv
// -----------------------------------------------------------------------------
// fixed_to_float_seq
// Sequential converter from signed fixed point (value = FIXED / 2^FRAC) to an
// IEEE-754 single. The magnitude is shifted one bit per cycle until its
// leading one sits on the hidden-bit position, then sign/exponent/mantissa
// are packed (mantissa truncated).
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   START       conversion request, honoured only in IDLE
//   FIXED       signed operand, captured on the accepting edge
//   BUSY        high from the accepting edge until the edge that raises DONE
//   DONE        one-cycle pulse, FLOAT valid while high
//   FLOAT       result, held until the next DONE
//   o_dbg_state current FSM state for observation
// Handshake: a request is START=1 sampled on a rising edge while the FSM is in
// IDLE; every other START is dropped. DONE=1 for exactly one cycle marks a
// valid FLOAT, and the FSM is already back in IDLE during that cycle, so a
// START held there is accepted on the following edge.
// -----------------------------------------------------------------------------
module fixed_to_float_seq
   import fixed_to_float_seq_pkg::*;
#(
   parameter int P    = F2F_WORD_W,
   parameter int FRAC = F2F_HIDDEN_BIT
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [P-1:0]  FIXED,
   output logic          BUSY,
   output logic          DONE,
   output logic [P-1:0]  FLOAT,
   output state_t        o_dbg_state
);

   localparam logic [F2F_EXP_W-1:0] EXP_BIAS = F2F_EXP_W'(F2F_EXP_BIAS);

   state_t                r_state;
   state_t                w_next_state;
   mag_op_t               w_mag_op;
   logic [P-1:0]          w_mag;
   logic [P-1:0]          w_abs;
   logic                  r_sign;
   logic [F2F_EXP_W-1:0]  r_exp;
   logic                  r_busy;
   logic                  r_done;
   logic [P-1:0]          r_float;

   // Negating the most negative value wraps back to itself, which read as
   // unsigned is exactly its magnitude.
   assign w_abs = FIXED[P-1] ? (-FIXED) : FIXED;

   shift_reg_norm #(
      .W (P)
   ) u_mag (
      .i_clk      (CLK),
      .i_rst_n    (RST),
      .i_op       (w_mag_op),
      .i_load_val (w_abs),
      .o_mag      (w_mag)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_mag_op     = MAG_HOLD;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_mag_op     = MAG_LOAD;
               w_next_state = (FIXED == '0) ? ST_PACK : ST_NORM;
            end
         end
         ST_NORM: begin
            // Too large first, then too small, else the leading one is home.
            if (|w_mag[P-1:FRAC+1]) begin
               w_mag_op = MAG_SHR;
            end else if (!w_mag[FRAC]) begin
               w_mag_op = MAG_SHL;
            end else begin
               w_next_state = ST_PACK;
            end
         end
         ST_PACK: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Sign, exponent and handshake registers follow the chosen magnitude op.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_float <= '0;
      end else begin
         r_done <= 1'b0;
         case (w_mag_op)
            MAG_LOAD: begin
               r_sign <= FIXED[P-1];
               r_exp  <= EXP_BIAS;
               r_busy <= 1'b1;
            end
            MAG_SHR: r_exp <= r_exp + 1'b1;
            MAG_SHL: r_exp <= r_exp - 1'b1;
            default: r_exp <= r_exp;
         endcase
         if (r_state == ST_PACK) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            // A zero magnitude has no leading one; emit +0 regardless of sign.
            if (w_mag == '0) begin
               r_float <= '0;
            end else begin
               r_float <= {r_sign, r_exp, w_mag[F2F_MANT_HI:F2F_MANT_LO]};
            end
         end
      end
   end

   assign BUSY        = r_busy;
   assign DONE        = r_done;
   assign FLOAT       = r_float;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// -----------------------------------------------------------------------------
// tb_fixed_to_float_seq
// Directed bench for fixed_to_float_seq. Inputs change and outputs are sampled
// on the falling edge. Latency n counts rising edges after the accepting edge,
// so DONE is expected at n = shifts + 2 (zero input: n = 1).
// -----------------------------------------------------------------------------
module tb_fixed_to_float_seq;
   import fixed_to_float_seq_pkg::*;

   logic         CLK = 1'b0;
   logic         RST;
   logic         START;
   logic [31:0]  FIXED;
   logic         BUSY;
   logic         DONE;
   logic [31:0]  FLOAT;
   state_t       dbg_state;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [31:0]  exp_q[$];

   fixed_to_float_seq dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .FIXED       (FIXED),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .FLOAT       (FLOAT),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Called on a falling edge; returns on the falling edge after the
   // accepting edge with START low and FIXED scrambled.
   task automatic start_conv(input logic [31:0] f);
      START = 1'b1;
      FIXED = f;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      FIXED = $urandom;
   endtask

   task automatic wait_done(input string tag, input int n0, input int exp_lat);
      int          n;
      logic [31:0] e;
      n = n0;
      while (DONE !== 1'b1 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check({tag, " done"},  32'(DONE), 32'd1);
      check({tag, " lat"},   n,         exp_lat);
      check({tag, " float"}, FLOAT,     e);
      check({tag, " busy0"}, 32'(BUSY), 32'd0);
   endtask

   task automatic count_dones(input int cycles, output int c);
      c = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) c++;
      end
   endtask

   task automatic run_case(input string tag, input logic [31:0] f,
                           input logic [31:0] exp_f, input int exp_lat);
      exp_q.push_back(exp_f);
      start_conv(f);
      check({tag, " busy1"}, 32'(BUSY), 32'd1);
      wait_done(tag, 0, exp_lat);
      @(negedge CLK);
      check({tag, " pulse"}, 32'(DONE), 32'd0);
      check({tag, " hold"},  FLOAT,     exp_f);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c;
      RST   = 1'b1;
      START = 1'b0;
      FIXED = '0;
      #1 RST = 1'b0;
      #2;
      check("rst busy",  32'(BUSY),      32'd0);
      check("rst done",  32'(DONE),      32'd0);
      check("rst float", FLOAT,          32'd0);
      check("rst state", 32'(dbg_state), 32'(ST_IDLE));
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      run_case("one",     32'h0400_0000, 32'h3F80_0000, 2);
      run_case("neg_one", 32'hFC00_0000, 32'hBF80_0000, 2);
      run_case("one_p5",  32'h0600_0000, 32'h3FC0_0000, 2);
      run_case("min_neg", 32'h8000_0000, 32'hC200_0000, 7);
      run_case("two",     32'h0800_0000, 32'h4000_0000, 3);
      run_case("lsb",     32'h0000_0001, 32'h3280_0000, 28);
      run_case("zero",    32'h0000_0000, 32'h0000_0000, 1);
      run_case("neg_lsb", 32'hFFFF_FFFF, 32'hB280_0000, 28);

      // START pulse while busy must be dropped, not queued.
      exp_q.push_back(32'h3280_0000);
      start_conv(32'h0000_0001);
      repeat (3) @(negedge CLK);
      START = 1'b1;
      FIXED = 32'h0400_0000;
      @(negedge CLK);
      START = 1'b0;
      check("busy_ign busy1", 32'(BUSY), 32'd1);
      wait_done("busy_ign", 4, 28);
      count_dones(40, c);
      check("busy_ign extra", c, 32'd0);

      // Reset in the middle of normalization aborts silently.
      start_conv(32'h0000_0001);
      repeat (4) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      check("abort busy",  32'(BUSY),      32'd0);
      check("abort float", FLOAT,          32'd0);
      check("abort done",  32'(DONE),      32'd0);
      check("abort state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge CLK);
      RST = 1'b1;
      count_dones(40, c);
      check("abort no_done", c, 32'd0);
      run_case("post_rst", 32'h0600_0000, 32'h3FC0_0000, 2);

      // START raised in the DONE cycle is taken on the next edge.
      exp_q.push_back(32'h3F80_0000);
      start_conv(32'h0400_0000);
      wait_done("b2b_a", 0, 2);
      exp_q.push_back(32'hBF80_0000);
      START = 1'b1;
      FIXED = 32'hFC00_0000;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      FIXED = $urandom;
      check("b2b_b busy1", 32'(BUSY), 32'd1);
      wait_done("b2b_b", 0, 2);
      @(negedge CLK);
      check("b2b_b pulse", 32'(DONE), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
